// File: rtl/ext_pipe.sv
// ext_pipe: registered immediate extender for the MIPS decode stage.
// It accepts a raw immediate and an extension mode over valid/ready. The
// extended operand appears one cycle later from a 2-entry skid buffer, so
// upstream stalls never drop an entry.
//
// Modes (ext_type):
//   000 zero-extend
//   001 sign-extend
//   010 upper (lui)
//   011 sign-extend, then <<2
//   100 zero-extend, then <<2
//   101/110/111 illegal: data=0, err=1
//
// Ports:
//   clk, reset         rising-edge clock; synchronous active-high reset
//   flush              squashes all buffered entries
//   in_valid/in_ready  upstream handshake; imm, ext_type are the request
//   out_valid/out_ready downstream handshake; out_data, out_err are the result
//   err_cnt            saturating count of accepted illegal modes
//
// Optional feature macro: EXT_ERRCNT_EN enables the err_cnt counter.
// When the macro is undefined, err_cnt is tied to zero.
module ext_pipe #(
  parameter int IMM_W    = 16,
  parameter int OUT_W    = 32,
  parameter int ERRCNT_W = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                flush,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [IMM_W-1:0]    imm,
  input  logic [2:0]          ext_type,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [OUT_W-1:0]    out_data,
  output logic                out_err,
  output logic [ERRCNT_W-1:0] err_cnt
);

  typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;

  state_t state, state_nx;

  logic [OUT_W-1:0] out_data_p1, skid_data_p1, ext_data_p0;
  logic             out_err_p1, skid_err_p1, ext_err_p0;
  logic             acc, pop, load_out, load_skid, move_skid;

  function automatic logic ext_illegal(input logic [2:0] t);
    return (t > 3'b100);
  endfunction

  function automatic logic [OUT_W-1:0] ext_value(input logic [IMM_W-1:0] i,
                                                 input logic [2:0]       t);
    logic signed [OUT_W-1:0] s;
    logic        [OUT_W-1:0] z;
    logic        [OUT_W-1:0] r;
    s = {{(OUT_W-IMM_W){i[IMM_W-1]}}, i};
    z = {{(OUT_W-IMM_W){1'b0}}, i};
    case (t)
      3'b000:  r = z;
      3'b001:  r = s;
      3'b010:  r = {i, {(OUT_W-IMM_W){1'b0}}};
      3'b011:  r = s <<< 2;
      3'b100:  r = z << 2;
      default: r = '0;
    endcase
    return r;
  endfunction

  // Stage p0: combinational decode of the incoming request
  assign ext_data_p0 = ext_value(imm, ext_type);
  assign ext_err_p0  = ext_illegal(ext_type);

  // Ready comes from the state register alone, so it never depends on out_ready.
  assign in_ready  = (state != TWO);
  assign out_valid = (state != EMPTY);
  assign acc       = in_valid & in_ready & ~flush;
  assign pop       = out_valid & out_ready;

  always_comb begin
    state_nx  = state;
    load_out  = 1'b0;
    load_skid = 1'b0;
    move_skid = 1'b0;
    if (flush) begin
      state_nx = EMPTY;
    end else begin
      case (state)
        EMPTY: if (acc) begin
          state_nx = ONE;
          load_out = 1'b1;
        end
        ONE: begin
          if (acc && pop) begin
            load_out = 1'b1;
          end else if (acc) begin
            state_nx  = TWO;
            load_skid = 1'b1;
          end else if (pop) begin
            state_nx = EMPTY;
          end
        end
        TWO: if (pop) begin
          state_nx  = ONE;
          move_skid = 1'b1;
        end
        default: state_nx = EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) state <= EMPTY;
    else       state <= state_nx;
  end

  // Stage p1: output register and skid entry
  always_ff @(posedge clk) begin
    if (reset) begin
      out_data_p1 <= '0;
      out_err_p1  <= 1'b0;
    end else if (load_out) begin
      out_data_p1 <= ext_data_p0;
      out_err_p1  <= ext_err_p0;
    end else if (move_skid) begin
      out_data_p1 <= skid_data_p1;
      out_err_p1  <= skid_err_p1;
    end
  end

  always_ff @(posedge clk) begin
    if (load_skid) begin
      skid_data_p1 <= ext_data_p0;
      skid_err_p1  <= ext_err_p0;
    end
  end

  assign out_data = out_data_p1;
  assign out_err  = out_err_p1;

`ifdef EXT_ERRCNT_EN
  logic [ERRCNT_W-1:0] err_cnt_p1;

  // Counts at input transfer; acc already excludes flush cycles.
  always_ff @(posedge clk) begin
    if (reset)
      err_cnt_p1 <= '0;
    else if (acc && ext_err_p0 && (err_cnt_p1 != {ERRCNT_W{1'b1}}))
      err_cnt_p1 <= err_cnt_p1 + 1'b1;
  end

  assign err_cnt = err_cnt_p1;
`else
  assign err_cnt = '0;
`endif

endmodule

// File: tb/tb_ext_pipe.sv
module tb_ext_pipe;

  logic        clk = 1'b0;
  logic        reset, flush, in_valid, in_ready, out_valid, out_ready, out_err;
  logic [15:0] imm;
  logic [2:0]  ext_type;
  logic [31:0] out_data;
  logic [7:0]  err_cnt;

  int n_chk  = 0;
  int n_pass = 0;

  ext_pipe #(.IMM_W(16), .OUT_W(32), .ERRCNT_W(8)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .imm(imm), .ext_type(ext_type),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_err(out_err), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [15:0] i, input logic [2:0] t);
    in_valid = v;
    imm      = i;
    ext_type = t;
  endtask

  initial begin
    reset = 1'b1; flush = 1'b0; out_ready = 1'b1;
    drive(1'b0, 16'h0, 3'b000);
    step(); step();
    reset = 1'b0;
    check("rst_valid", out_valid, 0);
    check("rst_data",  out_data,  0);
    check("rst_err",   out_err,   0);
    check("rst_ready", in_ready,  1);
    check("rst_cnt",   err_cnt,   0);

    // Basic sign/zero extension, latency 1
    drive(1'b1, 16'h8001, 3'b001); step();
    check("sext_valid", out_valid, 1);
    check("sext_data",  out_data,  32'hFFFF8001);
    check("sext_err",   out_err,   0);
    drive(1'b1, 16'h8001, 3'b000); step();
    check("zext_data",  out_data,  32'h00008001);

    // Back-to-back upper / shifted modes
    drive(1'b1, 16'hC003, 3'b010); step();
    check("lui_data",   out_data,  32'hC0030000);
    drive(1'b1, 16'hC003, 3'b011); step();
    check("sshl_data",  out_data,  32'hFFFF000C);
    drive(1'b1, 16'hC003, 3'b100); step();
    check("zshl_data",  out_data,  32'h0003000C);
    check("zshl_valid", out_valid, 1);
    drive(1'b0, 16'h0, 3'b000); step();
    check("drain_valid", out_valid, 0);

    // Skid fill with downstream stalled, then drain in order
    out_ready = 1'b0;
    drive(1'b1, 16'h0001, 3'b000); step();
    check("a_data",   out_data, 1);
    check("a_ready",  in_ready, 1);
    drive(1'b1, 16'h0002, 3'b000); step();
    check("two_ready", in_ready, 0);
    check("two_data",  out_data, 1);
    drive(1'b1, 16'h0003, 3'b000); step();
    check("hold_data",  out_data,  1);
    check("hold_valid", out_valid, 1);
    check("hold_ready", in_ready,  0);
    out_ready = 1'b1; step();
    check("b_data",  out_data, 2);
    check("b_ready", in_ready, 1);
    step();
    check("c_data",  out_data,  3);
    check("c_valid", out_valid, 1);
    drive(1'b0, 16'h0, 3'b000); step();
    check("c_drain", out_valid, 0);

    // Flush while full, with a simultaneous request
    out_ready = 1'b0;
    drive(1'b1, 16'h0001, 3'b000); step();
    drive(1'b1, 16'h0002, 3'b000); step();
    check("f_two_ready", in_ready, 0);
    flush = 1'b1;
    drive(1'b1, 16'h0004, 3'b000); step();
    check("flush_valid", out_valid, 0);
    check("flush_ready", in_ready,  1);
    flush = 1'b0; out_ready = 1'b1;
    drive(1'b0, 16'h0, 3'b000); step();
    check("flush_nod", out_valid, 0);

    // Illegal modes
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, 16'h1234, 3'b111); step();
      check("ill_data",  out_data, 0);
      check("ill_err",   out_err,  1);
      check("ill_valid", out_valid, 1);
    end
    drive(1'b0, 16'h0, 3'b000); step();
`ifdef EXT_ERRCNT_EN
    check("cnt3", err_cnt, 3);
`else
    check("cnt3", err_cnt, 0);
`endif
    drive(1'b1, 16'h1234, 3'b101);
    for (int k = 0; k < 257; k++) step();
    drive(1'b0, 16'h0, 3'b000); step();
`ifdef EXT_ERRCNT_EN
    check("cnt_sat", err_cnt, 255);
`else
    check("cnt_sat", err_cnt, 0);
`endif

    // Reset while full
    out_ready = 1'b0;
    drive(1'b1, 16'h0011, 3'b000); step();
    drive(1'b1, 16'h0022, 3'b000); step();
    check("r_two_ready", in_ready, 0);
    check("r_two_data",  out_data, 32'h11);
    reset = 1'b1; step();
    reset = 1'b0;
    drive(1'b0, 16'h0, 3'b000);
    check("mrst_valid", out_valid, 0);
    check("mrst_data",  out_data,  0);
    check("mrst_ready", in_ready,  1);
    check("mrst_cnt",   err_cnt,   0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
